// File: rtl/tdc_echo_meter.sv
// tdc_echo_meter: multi-channel round-trip time-to-digital converter.
// Fires a test pulse, timestamps the first echo edge per channel with a
// coarse cycle count plus a fine delay-line code, then streams one result
// word per channel over a valid/ready port.
// Optional feature macro: TDC_BUBBLE_FILTER_EN selects a popcount fine code
// (bubble tolerant) with one extra pipeline register; otherwise the fine
// code is the highest set tap index + 1 and is captured without delay.

module tdc_echo_meter #(
   parameter int  NCH       = 2,
   parameter int  TAPS      = 64,
   parameter int  COARSE_W  = 16,
   parameter int  PULSE_LEN = 4,
   parameter int  TIMEOUT   = 1000,
   localparam int FW        = $clog2(TAPS) + 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic                free_run,
   output logic                test_out,
   input  logic [NCH*TAPS-1:0] taps_i,
   output logic                res_valid,
   input  logic                res_ready,
   output logic [2:0]          res_ch,
   output logic [COARSE_W-1:0] res_coarse,
   output logic [FW-1:0]       res_fine,
   output logic [1:0]          res_flags,
   output logic                busy
);

   localparam logic [COARSE_W-1:0] PL_END  = COARSE_W'(PULSE_LEN - 1);
   localparam logic [COARSE_W-1:0] TO_CNT  = COARSE_W'(TIMEOUT);
   localparam logic [2:0]          LAST_CH = 3'(NCH - 1);

   typedef enum logic [1:0] {IDLE, FIRE, WAIT, DRAIN} state_t;

   state_t              state, state_nxt;
   logic [COARSE_W-1:0] cnt;
   logic [2:0]          rd_idx;

   logic [NCH-1:0]      done;
   logic [COARSE_W-1:0] cap_coarse [NCH];
   logic [FW-1:0]       cap_fine   [NCH];
   logic [1:0]          cap_flags  [NCH];

   logic                live;
   logic                arm;
   logic                tmo;
   logic [NCH-1:0]      seen;
   logic [NCH-1:0]      hit_cm;
   logic [NCH-1:0]      done_now;
   logic [COARSE_W-1:0] cnt_cm;
   logic [FW-1:0]       fine_cm [NCH];

   // Coarse counter increment that sticks at all ones instead of wrapping.
   function automatic logic [COARSE_W-1:0] sat_inc(input logic [COARSE_W-1:0] c);
      return (c == '1) ? c : c + 1'b1;
   endfunction

`ifdef TDC_BUBBLE_FILTER_EN
   // Number of set taps; tolerant to isolated bubbles in the thermometer code.
   function automatic logic [FW-1:0] pop_fine(input logic [TAPS-1:0] s);
      logic [FW-1:0] r;
      r = '0;
      for (int i = 0; i < TAPS; i++) r = r + FW'(s[i]);
      return r;
   endfunction
`else
   // Highest set tap index plus one; zero when no tap is set.
   function automatic logic [FW-1:0] prio_fine(input logic [TAPS-1:0] s);
      logic [FW-1:0] r;
      r = '0;
      for (int i = 0; i < TAPS; i++) if (s[i]) r = FW'(i + 1);
      return r;
   endfunction
`endif

   assign live = (state == FIRE) || (state == WAIT);
   assign arm  = (state == FIRE) && (cnt == '0);

   // Per-channel edge presence: any tap set in the channel slice.
   always_comb begin
      seen = '0;
      for (int c = 0; c < NCH; c++) seen[c] = |taps_i[c*TAPS +: TAPS];
   end

`ifdef TDC_BUBBLE_FILTER_EN
   logic [NCH-1:0]      hit_p0;
   logic [NCH-1:0]      vld_p1;
   logic [FW-1:0]       fine_p1 [NCH];
   logic [COARSE_W-1:0] cnt_p1;

   // Detection: first nonzero slice on an armed, idle channel with no capture in flight.
   always_comb begin
      hit_p0 = '0;
      for (int c = 0; c < NCH; c++)
         hit_p0[c] = live && !arm && !done[c] && !vld_p1[c] && seen[c];
   end

   // Stage p0 -> p1: detection flag travels with its popcount and counter value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) vld_p1 <= '0;
      else        vld_p1 <= hit_p0;
   end

   // Data half of the p1 stage; never read unless vld_p1 is set.
   always_ff @(posedge clk) begin
      cnt_p1 <= cnt;
      for (int c = 0; c < NCH; c++) fine_p1[c] <= pop_fine(taps_i[c*TAPS +: TAPS]);
   end

   // Commit point sits one stage after detection.
   always_comb begin
      hit_cm = vld_p1 & {NCH{live}};
      cnt_cm = cnt_p1;
      for (int c = 0; c < NCH; c++) fine_cm[c] = fine_p1[c];
   end
`else
   // Commit point is the detection cycle itself.
   always_comb begin
      hit_cm = '0;
      cnt_cm = cnt;
      for (int c = 0; c < NCH; c++) begin
         hit_cm[c]  = live && !arm && !done[c] && seen[c];
         fine_cm[c] = prio_fine(taps_i[c*TAPS +: TAPS]);
      end
   end
`endif

   // A capture landing in the timeout cycle counts as done, so it beats the timeout.
   assign done_now = done | hit_cm;
   assign tmo      = (state == WAIT) && (cnt_cm >= TO_CNT);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state decode and state-driven outputs.
   always_comb begin
      state_nxt = state;
      test_out  = 1'b0;
      busy      = 1'b1;
      res_valid = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start || free_run) state_nxt = FIRE;
         end
         FIRE: begin
            test_out = 1'b1;
            if (cnt >= PL_END) state_nxt = WAIT;
         end
         WAIT: begin
            if ((&done_now) || tmo) state_nxt = DRAIN;
         end
         DRAIN: begin
            res_valid = 1'b1;
            if (res_ready && (rd_idx == LAST_CH)) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Coarse counter: zero in the first FIRE cycle, saturating count through WAIT.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                 cnt <= '0;
      else if (state == IDLE && state_nxt == FIRE) cnt <= '0;
      else if (live)                              cnt <= sat_inc(cnt);
   end

   // Drain pointer: steps per accepted word, back to channel 0 after the last.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         rd_idx <= '0;
      else if (state != DRAIN)
         rd_idx <= '0;
      else if (res_ready)
         rd_idx <= (rd_idx == LAST_CH) ? 3'd0 : rd_idx + 3'd1;
   end

   // Per-channel capture: arm/stuck check, echo capture, or timeout fill.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         done <= '0;
         for (int c = 0; c < NCH; c++) begin
            cap_coarse[c] <= '0;
            cap_fine[c]   <= '0;
            cap_flags[c]  <= '0;
         end
      end else begin
         for (int c = 0; c < NCH; c++) begin
            if (arm) begin
               done[c]       <= seen[c];
               cap_coarse[c] <= '0;
               cap_fine[c]   <= '0;
               cap_flags[c]  <= seen[c] ? 2'b10 : 2'b00;
            end else if (hit_cm[c]) begin
               done[c]       <= 1'b1;
               cap_coarse[c] <= cnt_cm;
               cap_fine[c]   <= fine_cm[c];
               cap_flags[c]  <= 2'b00;
            end else if (tmo && !done[c]) begin
               done[c]       <= 1'b1;
               cap_coarse[c] <= '1;
               cap_fine[c]   <= '0;
               cap_flags[c]  <= 2'b01;
            end
         end
      end
   end

   // Result word selected by the drain pointer; captures are frozen during DRAIN.
   always_comb begin
      res_ch     = rd_idx;
      res_coarse = '0;
      res_fine   = '0;
      res_flags  = '0;
      for (int c = 0; c < NCH; c++) begin
         if (rd_idx == 3'(c)) begin
            res_coarse = cap_coarse[c];
            res_fine   = cap_fine[c];
            res_flags  = cap_flags[c];
         end
      end
   end

endmodule

// File: tb/tb_tdc_echo_meter.sv
// Directed testbench for tdc_echo_meter (NCH=2, TAPS=64, PULSE_LEN=4, TIMEOUT=1000).

module tb_tdc_echo_meter;

   localparam int NCH = 2;
   localparam int TAPS = 64;
   localparam int CW = 16;
   localparam int FW = $clog2(TAPS) + 1;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            start;
   logic            free_run;
   logic            test_out;
   logic [NCH*TAPS-1:0] taps;
   logic            res_valid;
   logic            res_ready;
   logic [2:0]      res_ch;
   logic [CW-1:0]   res_coarse;
   logic [FW-1:0]   res_fine;
   logic [1:0]      res_flags;
   logic            busy;

   int n_tot = 0;
   int n_bad = 0;

`ifdef TDC_BUBBLE_FILTER_EN
   localparam int BUBBLE_FINE = 4;
`else
   localparam int BUBBLE_FINE = 5;
`endif

   always #5 clk = ~clk;

   tdc_echo_meter #(
      .NCH(NCH), .TAPS(TAPS), .COARSE_W(CW), .PULSE_LEN(4), .TIMEOUT(1000)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .free_run(free_run),
      .test_out(test_out), .taps_i(taps), .res_valid(res_valid),
      .res_ready(res_ready), .res_ch(res_ch), .res_coarse(res_coarse),
      .res_fine(res_fine), .res_flags(res_flags), .busy(busy)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tot++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic set_tap(input int ch, input logic [63:0] v);
      taps[ch*TAPS +: TAPS] = v;
   endtask

   // Leaves the bench in the first FIRE cycle (counter = 0).
   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic check_reset_outs(input string tag);
      check({tag, "_test_out"}, 32'(test_out), 0);
      check({tag, "_valid"},    32'(res_valid), 0);
      check({tag, "_ch"},       32'(res_ch), 0);
      check({tag, "_coarse"},   32'(res_coarse), 0);
      check({tag, "_fine"},     32'(res_fine), 0);
      check({tag, "_flags"},    32'(res_flags), 0);
      check({tag, "_busy"},     32'(busy), 0);
   endtask

   task automatic expect_word(input string tag, input int ch, input int co,
                              input int fi, input int fl);
      int i;
      res_ready = 1'b1;
      i = 0;
      while (!res_valid && i < 2000) begin
         tick();
         i++;
      end
      check({tag, "_valid"}, 32'(res_valid), 1);
      if (res_valid) begin
         check({tag, "_ch"},     32'(res_ch), 32'(ch));
         check({tag, "_coarse"}, 32'(res_coarse), 32'(co));
         check({tag, "_fine"},   32'(res_fine), 32'(fi));
         check({tag, "_flags"},  32'(res_flags), 32'(fl));
         tick();
      end
      res_ready = 1'b0;
   endtask

   initial begin
      rst_n = 1'b1; start = 1'b0; free_run = 1'b0; res_ready = 1'b0; taps = '0;
      #2 rst_n = 1'b0;
      ticks(3);
      check_reset_outs("rst");
      rst_n = 1'b1;
      tick();

      // Both channels echo 0x1F in counter cycle 22.
      do_start();
      check("a_busy_fire", 32'(busy), 1);
      check("a_pulse_first", 32'(test_out), 1);
      ticks(3);
      check("a_pulse_last", 32'(test_out), 1);
      tick();
      check("a_pulse_end", 32'(test_out), 0);
      check("a_busy_wait", 32'(busy), 1);
      check("a_no_early_valid", 32'(res_valid), 0);
      ticks(18);
      set_tap(0, 64'h1F); set_tap(1, 64'h1F);
      tick();
      taps = '0;
      expect_word("a0", 0, 22, 5, 0);
      expect_word("a1", 1, 22, 5, 0);
      check("a_busy_idle", 32'(busy), 0);

      // Bubble in the thermometer code: ones at taps 0,1,2,4.
      do_start();
      ticks(30);
      set_tap(0, 64'h17); set_tap(1, 64'h17);
      tick();
      taps = '0;
      expect_word("b0", 0, 30, BUBBLE_FINE, 0);
      expect_word("b1", 1, 30, BUBBLE_FINE, 0);

      // Channel 1 never answers.
      do_start();
      ticks(40);
      set_tap(0, 64'h1F);
      tick();
      taps = '0;
      expect_word("t0", 0, 40, 5, 0);
      expect_word("t1", 1, 16'hFFFF, 0, 1);
      check("t_busy_idle", 32'(busy), 0);

      // Echo exactly in the timeout cycle is captured, not flagged.
      do_start();
      ticks(1000);
      set_tap(0, 64'h1);
      tick();
      taps = '0;
      expect_word("e0", 0, 1000, 1, 0);
      expect_word("e1", 1, 16'hFFFF, 0, 1);

      // Channel 0 already active when armed.
      set_tap(0, 64'h3);
      do_start();
      tick();
      set_tap(0, 64'h0);
      ticks(9);
      set_tap(1, 64'h1F);
      tick();
      taps = '0;
      expect_word("s0", 0, 0, 0, 2);
      expect_word("s1", 1, 10, 5, 0);

      // Consumer stalls for 10 cycles, then drains with free_run set.
      do_start();
      ticks(12);
      set_tap(0, 64'hFF); set_tap(1, 64'h1);
      tick();
      taps = '0;
      for (int i = 0; i < 20 && !res_valid; i++) tick();
      for (int i = 0; i < 10; i++) begin
         check("st_valid",  32'(res_valid), 1);
         check("st_ch",     32'(res_ch), 0);
         check("st_coarse", 32'(res_coarse), 12);
         check("st_fine",   32'(res_fine), 8);
         tick();
      end
      free_run = 1'b1;
      expect_word("st0", 0, 12, 8, 0);
      expect_word("st1", 1, 12, 1, 0);
      check("fr_idle_busy", 32'(busy), 0);
      check("fr_idle_pulse", 32'(test_out), 0);
      tick();
      check("fr_fire_pulse", 32'(test_out), 1);
      check("fr_fire_busy", 32'(busy), 1);
      free_run = 1'b0;

      // Reset in WAIT after channel 0 has captured.
      ticks(20);
      set_tap(0, 64'hF);
      tick();
      rst_n = 1'b0;
      tick();
      check_reset_outs("mid_rst");
      taps = '0;
      rst_n = 1'b1;
      tick();

      // Fresh run; later activity on channel 1 must be ignored.
      do_start();
      ticks(7);
      set_tap(1, 64'h3);
      tick();
      set_tap(1, 64'hFF);
      tick();
      set_tap(0, 64'h7);
      tick();
      taps = '0;
      expect_word("f0", 0, 9, 3, 0);
      expect_word("f1", 1, 7, 2, 0);
      check("f_busy_idle", 32'(busy), 0);

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

endmodule
